// File: rtl/sprite_scan_store.sv
// sprite_scan_store: scans NUM_OAM OAM entries per line, buffers up to MAX_SPRITES hits, answers per-pixel X queries.
// Optional sticky overflow flag: define SPRITE_OVERFLOW_EN.
module sprite_scan_store #(
  parameter int NUM_OAM     = 40,
  parameter int MAX_SPRITES = 10,
  parameter int IDX_W       = 6,
  parameter int X_W         = 8
) (
  input  logic             clk1,
  input  logic             reset_video,
  input  logic             scan_start,
  input  logic [7:0]       ly,
  input  logic             ff40_d1,
  input  logic             ff40_d2,
  output logic             oam_rd,
  output logic [IDX_W-1:0] oam_addr,
  input  logic             oam_valid,
  input  logic [7:0]       oam_y,
  input  logic [X_W-1:0]   oam_x,
  output logic             scanning,
  output logic             scan_done,
  output logic [4:0]       sprite_count,
  input  logic [X_W-1:0]   query_x,
  output logic             match_valid,
  output logic [3:0]       match_slot,
  output logic [IDX_W-1:0] match_idx,
  output logic [3:0]       match_row,
  input  logic             slot_clear,
  input  logic [3:0]       slot_clear_id,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t                 state;
  logic [7:0]             ly_q;
  logic                   tall_q;
  logic [MAX_SPRITES-1:0] valid;
  logic [IDX_W-1:0]       slot_idx [MAX_SPRITES];
  logic [X_W-1:0]         slot_x   [MAX_SPRITES];
  logic [3:0]             slot_row [MAX_SPRITES];
  logic [7:0]             row;
  logic                   hit, full, take, last;
  // Row wraps in 8 bits, so off-screen Y values land far above the height limit.
  assign row  = ly_q + 8'd16 - oam_y;
  assign hit  = ff40_d1 && row < (tall_q ? 8'd16 : 8'd8);
  assign full = sprite_count >= 5'(MAX_SPRITES);
  assign take = state == SCAN && oam_valid && hit;
  assign last = oam_addr == IDX_W'(NUM_OAM - 1);
  always_ff @(posedge clk1 or posedge reset_video) begin
    if (reset_video) begin
      state        <= IDLE;
      valid        <= '0;
      sprite_count <= 5'd0;
      oam_rd       <= 1'b0;
      oam_addr     <= '0;
      scanning     <= 1'b0;
      scan_done    <= 1'b0;
      ly_q         <= 8'd0;
      tall_q       <= 1'b0;
    end else if (scan_start) begin
      state        <= SCAN;
      valid        <= '0;
      sprite_count <= 5'd0;
      oam_rd       <= 1'b1;
      oam_addr     <= '0;
      scanning     <= 1'b1;
      scan_done    <= 1'b0;
      ly_q         <= ly;
      tall_q       <= ff40_d2;
    end else if (state == SCAN) begin
      if (oam_valid) begin
        if (hit && !full) begin
          for (int i = 0; i < MAX_SPRITES; i++)
            if (sprite_count == 5'(i)) valid[i] <= 1'b1;
          sprite_count <= sprite_count + 5'd1;
        end
        if (last) begin
          state     <= DONE;
          oam_rd    <= 1'b0;
          scanning  <= 1'b0;
          scan_done <= 1'b1;
        end else
          oam_addr <= oam_addr + 1'b1;
      end
    end else begin
      scan_done <= 1'b0;
      state     <= IDLE;
      for (int i = 0; i < MAX_SPRITES; i++)
        if (slot_clear && slot_clear_id == 4'(i)) valid[i] <= 1'b0;
    end
  end
  always_ff @(posedge clk1)
    for (int i = 0; i < MAX_SPRITES; i++)
      if (take && !full && sprite_count == 5'(i)) begin
        slot_idx[i] <= oam_addr;
        slot_x[i]   <= oam_x;
        slot_row[i] <= row[3:0];
      end
  // Scan high to low so the lowest matching slot is the one left standing.
  always_comb begin
    match_valid = 1'b0;
    match_slot  = 4'd0;
    match_idx   = '0;
    match_row   = 4'd0;
    for (int i = MAX_SPRITES - 1; i >= 0; i--)
      if (valid[i] && slot_x[i] == query_x) begin
        match_valid = 1'b1;
        match_slot  = 4'(i);
        match_idx   = slot_idx[i];
        match_row   = slot_row[i];
      end
  end
`ifdef SPRITE_OVERFLOW_EN
  always_ff @(posedge clk1 or posedge reset_video)
    if (reset_video) overflow <= 1'b0;
    else if (scan_start) overflow <= 1'b0;
    else if (take && full) overflow <= 1'b1;
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: doc/sprite_scan_store.md
Name: sprite_scan_store

Overview:
- Parametrised successor to the fixed 10-slot DMG sprite store.
- Scans N OAM entries per line and compares each Y against the current line (8- or 16-tall mode).
- Buffers up to MAX_SPRITES hits in order as {oam index, X, row}.
- Answers per-pixel X queries from the fetcher; the fetcher retires slots after fetching them.

Parameters:
NUM_OAM, 40, OAM entries scanned per line (2..256)
MAX_SPRITES, 10, store slots (1..16)
IDX_W, 6, OAM index width, ≥ clog2(NUM_OAM)
X_W, 8, sprite X width

Ports:
clk1  in  1  sole clock, rising edge
reset_video  in  1  async active-high reset
scan_start  in  1  one-cycle pulse at line start; begins/restarts scan
ly  in  8  current line, sampled on scan_start
ff40_d1  in  1  object enable; 0 masks all hits
ff40_d2  in  1  object height: 0 = 8 rows, 1 = 16 rows; sampled on scan_start
oam_rd  out  1  OAM read request
oam_addr  out  IDX_W  entry index requested
oam_valid  in  1  oam_y/oam_x valid for oam_addr this cycle
oam_y  in  8  entry Y (raw, +16 offset)
oam_x  in  X_W  entry X
scanning  out  1  high in SCAN state
scan_done  out  1  one-cycle pulse when scan completes
sprite_count  out  5  slots filled this line
query_x  in  X_W  current pixel X
match_valid  out  1  a valid slot has X == query_x
match_slot  out  4  lowest matching slot
match_idx  out  IDX_W  its OAM index
match_row  out  4  its row within sprite
slot_clear  in  1  retire slot slot_clear_id
slot_clear_id  in  4  slot to retire
overflow  out  1  see Optional Feature

Behaviour:
- Reset (async, any state): IDLE; all slot valid bits 0; sprite_count=0; oam_rd=0; oam_addr=0; scanning=0; scan_done=0; match_valid=0; overflow=0. Slot payload registers need not reset.
- FSM states: IDLE, SCAN, DONE.
- scan_start in any state:
  - next state SCAN; oam_addr=0;
  - all valid bits and sprite_count cleared; overflow cleared;
  - ly_q<=ly, tall_q<=ff40_d2.
- SCAN:
  - oam_rd=1 and oam_addr held until oam_valid=1.
  - On a cycle with oam_valid=1:
    - row = (ly_q + 16 − oam_y) mod 256;
    - hit = ff40_d1 && row < (tall_q ? 16 : 8).
    - If hit and sprite_count < MAX_SPRITES: slot[sprite_count] <= {oam_addr, oam_x, row[3:0]}, valid<=1, sprite_count++.
    - If hit and store full: no store; overflow<=1.
    - If oam_addr==NUM_OAM−1: next state DONE, oam_rd drops next cycle. Otherwise oam_addr++.
  - With oam_valid tied 1, one entry per cycle: scan_start at cycle 0, addr 0 at cycle 1, last entry at cycle NUM_OAM, DONE at cycle NUM_OAM+1.
- DONE: scan_done=1 for exactly one cycle, then IDLE. sprite_count and slots hold until the next scan_start.
- Query (combinational, not gated by state):
  - match_valid = any valid slot with X == query_x.
  - Lowest slot number wins, i.e. earliest OAM index.
  - match_* outputs are 0 when match_valid=0.
- slot_clear:
  - In IDLE/DONE: clears valid[slot_clear_id] next edge. Out-of-range id is ignored. sprite_count is unchanged.
  - In SCAN: ignored.
- Simultaneous events:
  - scan_start beats slot_clear and oam_valid in the same cycle; the entry is discarded.
  - ff40_d1 falling mid-scan masks hits from that cycle on; slots already stored remain.
- Row arithmetic is 8-bit wrap. Y=0 and Y≥160+16 simply never hit.

Optional Feature:
- Macro: SPRITE_OVERFLOW_EN.
- Defined: overflow is a sticky register. It is set when a hit is dropped because the store is full, cleared by scan_start/reset, and readable until the next scan_start.
- Undefined: the overflow port exists but is tied 0, and no overflow register is built.

Test Plan:
- Default params, oam_valid=1, ly=40, ff40_d2=0, entry3 Y=50 X=20, others Y=0 -> scan_done at cycle 41; sprite_count=1; query_x=20 gives match_idx=3, match_row=6.
- 12 entries with Y=56, ly=40, tall=0 -> sprite_count=10; slots hold idx 0..9; overflow=1 with SPRITE_OVERFLOW_EN, 0 without.
- tall=1, ly=40, Y=41 -> row=15, hit. Same stimulus with tall=0 -> no hit, sprite_count=0.
- Slots 2 and 5 share X=30 -> match_slot=2. After slot_clear id=2 in IDLE -> match_slot=5. Then slot_clear id=5 -> match_valid=0.
- oam_valid low 3 cycles per entry -> oam_addr and oam_rd held; results identical to the zero-wait run. scan_start pulsed at entry 17 -> count resets and addr restarts at 0.
- reset_video asserted mid-scan between clock edges -> outputs reach reset values immediately, before the next clk1 edge.
